// File: rtl/wired_resolve_pkg.sv
// Shared constants, buffer state type and saturating-increment helper for wired_resolve_pipe.
package wired_resolve_pkg;

   localparam int unsigned MODE_WAND = 0;
   localparam int unsigned MODE_WOR  = 1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_e;

   // Counters up to 32 bits wide; the caller truncates back to its own width.
   function automatic logic [31:0] sat_inc(input logic [31:0] count, input int unsigned width);
      logic [31:0] max_val;
      max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return (count >= max_val) ? count : count + 32'd1;
   endfunction

endpackage

// File: rtl/wired_resolve_bit.sv
// Combinational single-bit wired-net resolver (wand/wor), with undriven and conflict flags.
// Conflict detection is built only when WIRED_RESOLVE_STATS_EN is defined.
module wired_resolve_bit
   import wired_resolve_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned MODE     = MODE_WAND
) (
   input  logic [CHANNELS-1:0] drv_bits,
   input  logic [CHANNELS-1:0] drv_en,
   output logic                value,
   output logic                zmask,
   output logic                conflict
);

   logic any_en;
   logic any_one;
   logic any_zero;

   always_comb begin
      any_en   = |drv_en;
      any_one  = |(drv_bits & drv_en);
      any_zero = |(~drv_bits & drv_en);
      zmask    = ~any_en;
      if (MODE == MODE_WOR) begin
         value = any_one;
      end else begin
         value = any_en & ~any_zero;
      end
`ifdef WIRED_RESOLVE_STATS_EN
      conflict = any_one & any_zero;
`else
      conflict = 1'b0;
`endif
   end

endmodule

// File: rtl/wired_resolve_pipe.sv
// Pipelined wired-net resolver behind a 2-entry valid/ready skid buffer.
// Define WIRED_RESOLVE_STATS_EN to build the conflict/undriven saturating counters.
module wired_resolve_pipe
   import wired_resolve_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MODE     = MODE_WAND,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [CHANNELS-1:0][WIDTH-1:0]  drv_data,
   input  logic [CHANNELS-1:0]             drv_en,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH-1:0]                out_data,
   output logic [WIDTH-1:0]                out_zmask,
   output logic [CNT_W-1:0]                conflict_cnt,
   output logic [CNT_W-1:0]                undriven_cnt
);

   logic [WIDTH-1:0] res_data;
   logic [WIDTH-1:0] res_zmask;
   logic [WIDTH-1:0] conflict_bits;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [CHANNELS-1:0] bits;
      always_comb begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            bits[c] = drv_data[c][i];
         end
      end
      wired_resolve_bit #(
         .CHANNELS (CHANNELS),
         .MODE     (MODE)
      ) u_bit (
         .drv_bits (bits),
         .drv_en   (drv_en),
         .value    (res_data[i]),
         .zmask    (res_zmask[i]),
         .conflict (conflict_bits[i])
      );
   end

   buf_state_e       state_q, state_d;
   logic [WIDTH-1:0] main_data_q, main_data_d;
   logic [WIDTH-1:0] main_zmask_q, main_zmask_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic [WIDTH-1:0] skid_zmask_q, skid_zmask_d;
   logic             accept;
   logic             emit;

   assign in_ready  = (state_q != TWO);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_data_q;
   assign out_zmask = main_zmask_q;
   assign accept    = in_valid & in_ready;
   assign emit      = out_valid & out_ready;

   // The main slot always feeds the output; the skid slot only fills while stalled in ONE.
   always_comb begin
      state_d      = state_q;
      main_data_d  = main_data_q;
      main_zmask_d = main_zmask_q;
      skid_data_d  = skid_data_q;
      skid_zmask_d = skid_zmask_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               main_data_d  = res_data;
               main_zmask_d = res_zmask;
               state_d      = ONE;
            end
         end
         ONE: begin
            if (accept && emit) begin
               main_data_d  = res_data;
               main_zmask_d = res_zmask;
            end else if (accept) begin
               skid_data_d  = res_data;
               skid_zmask_d = res_zmask;
               state_d      = TWO;
            end else if (emit) begin
               state_d      = EMPTY;
            end
         end
         TWO: begin
            if (emit) begin
               main_data_d  = skid_data_q;
               main_zmask_d = skid_zmask_q;
               state_d      = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         main_data_q  <= '0;
         main_zmask_q <= '0;
         skid_data_q  <= '0;
         skid_zmask_q <= '0;
      end else begin
         state_q      <= state_d;
         main_data_q  <= main_data_d;
         main_zmask_q <= main_zmask_d;
         skid_data_q  <= skid_data_d;
         skid_zmask_q <= skid_zmask_d;
      end
   end

`ifdef WIRED_RESOLVE_STATS_EN
   logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
   logic [CNT_W-1:0] undriven_cnt_q, undriven_cnt_d;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      undriven_cnt_d = undriven_cnt_q;
      if (accept) begin
         if (|conflict_bits) begin
            conflict_cnt_d = CNT_W'(sat_inc(32'(conflict_cnt_q), CNT_W));
         end
         if (drv_en == '0) begin
            undriven_cnt_d = CNT_W'(sat_inc(32'(undriven_cnt_q), CNT_W));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt_q <= '0;
         undriven_cnt_q <= '0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
         undriven_cnt_q <= undriven_cnt_d;
      end
   end

   assign conflict_cnt = conflict_cnt_q;
   assign undriven_cnt = undriven_cnt_q;
`else
   logic unused_conflict;
   assign unused_conflict = |conflict_bits;
   assign conflict_cnt    = '0;
   assign undriven_cnt    = '0;
`endif

endmodule

// File: doc/wired_resolve_pipe.md
# wired_resolve_pipe

Parametrised, pipelined wired-net resolver. Each accepted transaction carries CHANNELS driver words with per-channel drive enables. The block resolves them per bit with wand or wor semantics, marks undriven bits, and presents the result through a valid/ready skid buffer. It sits between multi-driver stimulus sources and downstream packed-array consumers, and replaces ad-hoc continuous wand/wor resolution with a registered, back-pressurable, instrumented stage.

## Interface
- CHANNELS, 4, number of driver channels (>=1)
- WIDTH, 8, bits per driver word (>=1)
- MODE, 0, resolution: 0 = wand (AND of enabled drivers), 1 = wor (OR of enabled drivers)
- CNT_W, 16, width of statistics counters (>=2)

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  transaction offered
- in_ready  output  1  block can accept
- drv_data  input  [CHANNELS][WIDTH]  driver words, channel 0 at index 0
- drv_en  input  [CHANNELS]  1 = channel drives, 0 = channel is high-Z
- out_valid  output  1  resolved word available
- out_ready  input  1  consumer accepts
- out_data  output  [WIDTH]  resolved word
- out_zmask  output  [WIDTH]  1 = no enabled driver on this bit
- conflict_cnt  output  [CNT_W]  saturating count of accepted words with any driver disagreement
- undriven_cnt  output  [CNT_W]  saturating count of accepted words with drv_en == 0

## Operation
- Accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
- Per bit, let E be the set of enabled channels:
  - E empty: out_data bit = 0 and out_zmask bit = 1.
  - Otherwise out_zmask bit = 0 and out_data bit = AND (MODE 0) or OR (MODE 1) over E.
- Conflict: for some bit, the enabled drivers do not all hold the same value. A single enabled driver never conflicts.
- Storage is a 2-entry buffer (main + skid). The FSM has three states:
  - EMPTY: accept -> ONE.
  - ONE: accept without emit -> TWO. Emit without accept -> EMPTY. Accept with emit -> ONE.
  - TWO: emit -> ONE. Accept is impossible because in_ready = 0.
- in_ready = (state != TWO), taken from registered state.
- Output order equals acceptance order. There is no drop and no duplication.
- Counters increment on accept, not on emit. They saturate at all-ones and never wrap.
- Simultaneous accept and emit in state ONE: the new word enters the main slot, and the emitted word leaves the same edge.

## Timing
- Latency is 1 cycle. A word accepted at edge N is visible on out_* after edge N when the buffer was EMPTY.
- Reset values:
  - state = EMPTY, out_valid = 0, in_ready = 1.
  - out_data = 0, out_zmask = 0.
  - conflict_cnt = 0, undriven_cnt = 0.
- Reset mid-operation: all buffered words are discarded immediately (asynchronous). There is no emit after reset deassertion until a new accept.
- out_data and out_zmask hold stable while out_valid && !out_ready.
- Counter update is visible 1 cycle after the accepting edge.

## Configuration
- WIRED_RESOLVE_STATS_EN defined: conflict detection and both saturating counters are built as specified.
- Undefined: no conflict logic or counter flops are built. conflict_cnt and undriven_cnt are tied to 0. Data path and handshake are unchanged.

## Structure
- Shared package wired_resolve_pkg holds:
  - the MODE_WAND = 0 and MODE_WOR = 1 constants;
  - the buffer state enum (EMPTY, ONE, TWO);
  - a function sat_inc(count) for saturating increment.
- One sub-module: wired_resolve_bit, a combinational per-bit resolver with outputs value, zmask and conflict, instantiated WIDTH times by generate.
- The top level holds the skid FSM, the storage and the counters.

## Test plan
All scenarios use CHANNELS=4 and WIDTH=8.
- MODE=0, drv_en=4'b0011, ch0=8'hF0, ch1=8'h3C -> out_data=8'h30, out_zmask=8'h00; conflict_cnt goes 0->1 one cycle after accept.
- MODE=1, same stimulus -> out_data=8'hFC, conflict_cnt=1.
- drv_en=4'b0000 -> out_data=8'h00, out_zmask=8'hFF, undriven_cnt=1, conflict_cnt unchanged. drv_en=4'b0100 with ch2=8'hA5 -> out_data=8'hA5, no conflict.
- Back-pressure: hold out_ready=0 and offer words 8'h01, 8'h02, 8'h03 back-to-back.
  - 8'h01 and 8'h02 are accepted; in_ready=0 from the cycle after the second accept.
  - Raise out_ready: 8'h01, 8'h02, then 8'h03 are emitted in order.
  - Accept-and-emit in the same cycle in state ONE keeps throughput at 1 word/cycle.
- Saturation: CNT_W=2, 5 consecutive conflicting words -> conflict_cnt reads 1, 2, 3, 3, 3.
- Reset mid-operation: assert rst asynchronously with 2 words buffered -> out_valid=0 and in_ready=1 immediately, counters=0, and no stale word appears after release.
- Rebuild without WIRED_RESOLVE_STATS_EN: both counters read 0 in every scenario above, and data results are identical.
